// File: rtl/vga_tile_fetch.sv
// Purpose : walks the visible TILES_X x TILES_Y tile window of the map once per frame,
//           issuing one tile-map read per tile and buffering the returned words.
// Latency : one tile per 2+ cycles (ISSUE, then WAIT until mem_ack); a word appears at
//           tile_data one cycle after its mem_ack.
// Backpressure: requests stall in ISSUE while the FIFO is full; tile_ready pops the head.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   frame_start                 vsync pulse; latches start_addr/row_length, (re)starts the walk
//   start_addr, row_length      map base address and row stride in words
//   mem_req/mem_addr/mem_ack/mem_rdata   single-outstanding read port, data valid with ack
//   tile_valid/tile_data/tile_ready      FIFO head to the pixel renderer
//   busy                        frame walk in progress
//   frame_done                  pulse when the frame's last word has entered the FIFO
//   underrun                    sticky "renderer wanted data while FIFO empty" flag,
//                               present only when VGA_TILE_FETCH_UNDERRUN_EN is defined

module vga_tile_fetch #(
    parameter int TILES_X    = 40,
    parameter int TILES_Y    = 30,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [15:0]       start_addr,
    input  logic [15:0]       row_length,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tile_valid,
    output logic [DATA_W-1:0] tile_data,
    input  logic              tile_ready,
    output logic              busy,
    output logic              frame_done
`ifdef VGA_TILE_FETCH_UNDERRUN_EN
    ,
    output logic              underrun
`endif
);

    localparam int CW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int RW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(TILES_X - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(TILES_Y - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       stride_q, stride_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              mem_req_q, mem_req_d;
    logic [15:0]       mem_addr_q, mem_addr_d;
    logic              frame_done_q, frame_done_d;

    logic              push;
    logic              pop;
    logic              flush;

    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [NW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;

    // ------------------------------------------------------------------
    // Walk FSM. frame_start takes priority over everything, so an abort
    // drops mem_req on the same edge and a coincident final ack is lost
    // (no push, no frame_done) in favour of the restart.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        stride_d     = stride_q;
        col_d        = col_q;
        row_d        = row_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;

        if (frame_start) begin
            state_d   = S_ISSUE;
            base_d    = start_addr;
            stride_d  = row_length;
            col_d     = '0;
            row_d     = '0;
            mem_req_d = 1'b0;
            flush     = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ISSUE: begin
                    // Only one request is ever outstanding, so a free slot
                    // now is still free when the ack's data arrives.
                    if (count_q < DEPTH_N) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = base_q + 16'(col_q);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        push      = 1'b1;
                        mem_req_d = 1'b0;
                        if (col_q != COL_LAST) begin
                            col_d   = col_q + 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            col_d  = '0;
                            base_d = base_q + stride_q;
                            if (row_q != ROW_LAST) begin
                                row_d   = row_q + 1'b1;
                                state_d = S_ISSUE;
                            end else begin
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            stride_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Tile FIFO with a registered head word.
    // ------------------------------------------------------------------
    assign pop = (count_q != '0) && tile_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = '0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Next head: the word being written this cycle becomes the head when
        // the FIFO was empty, or when it held one entry that is being popped.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = mem_rdata;
            end else begin
                head_d = fifo_mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

`ifdef VGA_TILE_FETCH_UNDERRUN_EN
    // Sticky for the whole frame so a renderer stall is visible to software
    // after the fact; a new frame starts with a clean flag.
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (frame_start) begin
            underrun_d = 1'b0;
        end else if ((state_q != S_IDLE) && tile_ready && (count_q == '0)) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`endif

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign tile_valid = (count_q != '0);
    assign tile_data  = head_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_tile_fetch.sv
module tb_vga_tile_fetch;

    localparam int TX = 4;
    localparam int TY = 3;
    localparam int FD = 8;
    localparam int DW = 16;
    localparam int NT = TX * TY;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic [15:0]   start_addr;
    logic [15:0]   row_length;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          tile_valid;
    logic [DW-1:0] tile_data;
    logic          tile_ready;
    logic          busy;
    logic          frame_done;
`ifdef VGA_TILE_FETCH_UNDERRUN_EN
    logic          underrun;
`endif

    vga_tile_fetch #(
        .TILES_X    (TX),
        .TILES_Y    (TY),
        .FIFO_DEPTH (FD),
        .DATA_W     (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .start_addr  (start_addr),
        .row_length  (row_length),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .tile_valid  (tile_valid),
        .tile_data   (tile_data),
        .tile_ready  (tile_ready),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef VGA_TILE_FETCH_UNDERRUN_EN
        ,
        .underrun    (underrun)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] tile_addr(input logic [15:0] sa, input logic [15:0] rl,
                                               input int r, input int c);
        logic [31:0] s;
        s = 32'(sa) + 32'(r) * 32'(rl) + 32'(c);
        return s[15:0];
    endfunction

    // ---------------- memory responder / ready driver (posedge + 1) ----------------
    int resp_mode  = 0;    // 0: auto random latency, 1: hold (acks only by inject)
    bit inject_ack = 1'b0;
    int rdy_mode   = 0;    // 0: fixed, 1: random
    bit rdy_fixed  = 1'b0;
    int lat        = 0;

    initial begin
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        tile_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tile_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_fixed;
            mem_ack    = 1'b0;
            mem_rdata  = 16'($urandom);
            if (!rst_n) begin
                lat = 0;
            end else if (inject_ack) begin
                mem_ack    = 1'b1;
                mem_rdata  = mem_word(mem_addr);
                inject_ack = 1'b0;
            end else if (mem_req && resp_mode == 0) begin
                if (lat == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    lat       = $urandom_range(0, 2);
                end else begin
                    lat--;
                end
            end
        end
    end

    // ---------------- reference model + scoreboard monitor (negedge) ----------------
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    bit          busy_m = 1'b0;
    int          occ_m  = 0;
    bit          fd_m   = 1'b0;
    int          acks_m = 0;
    bit          und_m  = 1'b0;
    int          fd_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_m = 1'b0; occ_m = 0; fd_m = 1'b0; acks_m = 0; und_m = 1'b0;
                exp_addr_q.delete();
                exp_data_q.delete();
            end else begin
                bit          hs, pp, und_next, have_a;
                logic [15:0] ea;
                check("busy", busy, busy_m);
                check("tile_valid", tile_valid, occ_m > 0);
                check("frame_done", frame_done, fd_m);
                if (frame_done) fd_seen++;
`ifdef VGA_TILE_FETCH_UNDERRUN_EN
                check("underrun", underrun, und_m);
`endif
                hs     = mem_req && mem_ack;
                pp     = tile_ready && (occ_m > 0);
                have_a = 1'b0;
                ea     = '0;
                if (hs) begin
                    if (exp_addr_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL mem_addr: unexpected handshake at 0x%0h, none expected", mem_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        have_a = 1'b1;
                        check("mem_addr", mem_addr, ea);
                    end
                end
                if (pp) begin
                    if (exp_data_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL tile_data: got 0x%0h, expected no word", tile_data);
                    end else begin
                        check("tile_data", tile_data, exp_data_q.pop_front());
                    end
                end
                und_next = und_m | (busy_m && tile_ready && occ_m == 0);
                fd_m = 1'b0;
                if (frame_start) begin
                    busy_m = 1'b1; occ_m = 0; acks_m = 0; und_m = 1'b0;
                    exp_addr_q.delete();
                    exp_data_q.delete();
                    for (int r = 0; r < TY; r++)
                        for (int c = 0; c < TX; c++)
                            exp_addr_q.push_back(tile_addr(start_addr, row_length, r, c));
                end else begin
                    und_m = und_next;
                    if (pp) occ_m--;
                    if (have_a) begin
                        occ_m++;
                        exp_data_q.push_back(mem_word(ea));
                        acks_m++;
                        if (acks_m == NT) begin
                            busy_m = 1'b0;
                            fd_m   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus (posedge + 2) ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_frame(input logic [15:0] sa, input logic [15:0] rl);
        start_addr  = sa;
        row_length  = rl;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int k = 0;
        while (acks_m < NT && k < budget) begin tick(); k++; end
        while (occ_m > 0 && k < budget) begin tick(); k++; end
        tick(2);
        check("frame_complete_in_budget", k < budget, 1'b1);
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        while (!mem_req && k < budget) begin tick(); k++; end
        check("req_in_budget", mem_req, 1'b1);
    endtask

    int exp_fd = 8;
    int req_seen;

    initial begin
        rst_n = 1'b1; frame_start = 1'b0; start_addr = '0; row_length = '0;
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_tile_valid", tile_valid, 1'b0);
        check("rst_tile_data", tile_data, 16'h0);
        rst_n = 1'b1;
        tick(2);

        // Basic walk
        rdy_fixed = 1'b1;
        start_frame(16'h0100, 16'h0040);
        wait_frame(400);

        // Randomized frames with random ready and memory latency
        repeat (3) begin
            rdy_mode = 1;
            start_frame(16'($urandom), 16'($urandom));
            wait_frame(800);
        end
        rdy_mode = 0;

        // Address wrap
        start_frame(16'hFFFE, 16'h0010);
        wait_frame(400);

        // Backpressure
        rdy_fixed = 1'b0;
        start_frame(16'h0300, 16'h0020);
        tick(60);
        check("bp_acks_full", acks_m, FD);
        check("bp_req_stalled", mem_req, 1'b0);
        check("bp_fifo_valid", tile_valid, 1'b1);
        rdy_fixed = 1'b1;
        tick();
        rdy_fixed = 1'b0;
        tick(20);
        check("bp_one_more_ack", acks_m, FD + 1);
        check("bp_req_stalled_again", mem_req, 1'b0);
        rdy_fixed = 1'b1;
        wait_frame(400);

        // Abort during WAIT of tile 5, plus a late ack while mem_req is low
        resp_mode = 1;
        start_frame(16'h0500, 16'h0020);
        repeat (5) begin
            wait_req(50);
            inject_ack = 1'b1;
            tick(2);
        end
        wait_req(50);
        check("abort_pre_acks", acks_m, 5);
        start_addr  = 16'h2000;
        row_length  = 16'h0040;
        frame_start = 1'b1;
        inject_ack  = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort_req_drop", mem_req, 1'b0);
        check("abort_fifo_flushed", tile_valid, 1'b0);
        check("abort_busy", busy, 1'b1);
        tick();
        resp_mode = 0;
        wait_frame(400);

        // frame_start coincident with the final ack: restart wins
        resp_mode = 1;
        start_frame(16'h0700, 16'h0100);
        repeat (NT - 1) begin
            wait_req(50);
            inject_ack = 1'b1;
            tick(2);
        end
        wait_req(50);
        inject_ack = 1'b1;
        tick();
        start_addr  = 16'h0A00;
        row_length  = 16'h0008;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("restart_busy", busy, 1'b1);
        check("restart_no_done", frame_done, 1'b0);
        resp_mode = 0;
        wait_frame(400);

`ifdef VGA_TILE_FETCH_UNDERRUN_EN
        exp_fd += 2;
        resp_mode = 1;
        start_frame(16'h1000, 16'h0040);
        tick(3);
        check("underrun_set", underrun, 1'b1);
        resp_mode = 0;
        tick(5);
        check("underrun_sticky_busy", underrun, 1'b1);
        wait_frame(400);
        check("underrun_sticky_idle", underrun, 1'b1);
        rdy_fixed = 1'b0;
        start_frame(16'h1100, 16'h0040);
        check("underrun_cleared", underrun, 1'b0);
        rdy_fixed = 1'b1;
        wait_frame(400);
`endif

        // Asynchronous reset in the middle of WAIT
        resp_mode = 1;
        start_frame(16'h0040, 16'h0010);
        wait_req(50);
        #1 rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_tile_valid", tile_valid, 1'b0);
        check("arst_frame_done", frame_done, 1'b0);
        tick(3);
        rst_n = 1'b1;
        resp_mode = 0;
        req_seen = 0;
        repeat (20) begin
            tick();
            if (mem_req) req_seen++;
        end
        check("post_rst_no_requests", req_seen, 0);
        check("post_rst_idle", busy, 1'b0);

        check("frame_done_count", fd_seen, exp_fd);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_tile_fetch.md
Name: vga_tile_fetch

Overview:
- Downstream consumer of the display start-address calculator.
- On each frame start it latches DisplayStartLocation and RowLength, then walks the visible tile window in row-major order: TILES_X tiles per row, TILES_Y rows.
- Issues one tile-map read per tile over a req/ack memory port and buffers the returned tile words in a small FIFO for the pixel renderer.

Parameters:
- TILES_X, 40, visible tiles per row.
- TILES_Y, 30, visible tile rows per frame.
- FIFO_DEPTH, 8, tile-word buffer entries (power of 2, >=2).
- DATA_W, 16, tile word width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse at vsync; begins a new frame walk.
- start_addr  in  16  DisplayStartLocation from the start-address calculator; sampled on frame_start.
- row_length  in  16  map row stride in words; sampled on frame_start.
- mem_req  out  1  read request.
- mem_addr  out  16  read address; valid while mem_req=1.
- mem_ack  in  1  read complete; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- tile_valid  out  1  FIFO not empty.
- tile_data  out  DATA_W  FIFO head word.
- tile_ready  in  1  renderer pop; a pop occurs when tile_valid & tile_ready.
- busy  out  1  frame walk in progress.
- frame_done  out  1  one-cycle pulse when the last tile word of a frame has been written into the FIFO.

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_req=0, mem_addr=0, busy=0, frame_done=0, tile_valid=0, tile_data=0. FIFO empty; all counters and latched registers 0.
- Registers:
  - base_q (row base address), col_q, row_q.
  - stride_q (latched row_length).
  - FIFO read/write pointers and count.
- FSM states:
  - IDLE: on frame_start, latch base_q<=start_addr and stride_q<=row_length; clear col_q, row_q and the FIFO; go to ISSUE. busy=1 from the next cycle.
  - ISSUE: if FIFO count < FIFO_DEPTH, assert mem_req with mem_addr=base_q+col_q (16-bit, modulo 2^16) and go to WAIT. Otherwise stay in ISSUE with mem_req=0.
  - WAIT: hold mem_req=1 and mem_addr stable until mem_ack.
    - On mem_ack, push mem_rdata.
    - If col_q != TILES_X-1: col_q++, go to ISSUE.
    - Else col_q<=0, base_q<=base_q+stride_q (wraps mod 2^16).
      - If row_q != TILES_Y-1: row_q++, go to ISSUE.
      - Else pulse frame_done, go to IDLE; busy=0 the cycle after.
- Single outstanding request only. Minimum 2 cycles per tile (ISSUE, then WAIT with a same-cycle ack).
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs when full; ISSUE gating guarantees a free slot.
  - Pop when empty is ignored.
  - tile_data is a registered head-of-FIFO value; first-word latency is 1 cycle after the push.
- frame_start while busy:
  - Abort: drop mem_req immediately (same edge), flush the FIFO, re-latch inputs, restart in ISSUE.
  - No frame_done for the aborted frame.
  - mem_ack arriving while mem_req=0 is ignored.
- frame_start in the same cycle as the final mem_ack: the restart wins; frame_done is not pulsed.
- tile_ready is honoured in all states, including IDLE after frame_done, so the FIFO drains normally.

Optional Feature:
- Macro VGA_TILE_FETCH_UNDERRUN_EN.
- When defined:
  - Adds output underrun (1 bit, reset 0).
  - Sticky set when busy=1, tile_ready=1 and the FIFO is empty in the same cycle.
  - Cleared only by frame_start or reset.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low mid-WAIT -> mem_req, busy, tile_valid drop to 0 asynchronously; after release the block stays IDLE with no requests.
- Basic walk (TILES_X=4, TILES_Y=2; start_addr=0x0100, row_length=0x0040; ack 1 cycle after each req; tile_ready=1) -> addresses 0x0100..0x0103, 0x0140..0x0143 in order; data emerges in order; one frame_done pulse after the 8th push.
- Backpressure (tile_ready=0, FIFO_DEPTH=8, TILES_X=40) -> exactly 8 acks then mem_req stays 0. Assert tile_ready for 1 cycle -> exactly one new request.
- Wrap: start_addr=0xFFFE, row_length=0x0010, TILES_X=4 -> row 0 addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; row 1 starts at 0x000E.
- Abort: frame_start during WAIT at tile 5 with start_addr=0x2000 -> mem_req falls that edge; FIFO empties; the next request goes to 0x2000; no frame_done for the aborted frame; a late mem_ack is ignored.
- Underrun (macro on): busy, FIFO empty, tile_ready=1 -> underrun=1 and stays set until the next frame_start.
